// File: rtl/clkdiv_prog.sv
// clkdiv_prog: programmable integer clock divider.
//
// Produces a registered, glitch-free divided clock (clko) from clk for the
// clock-tree cells downstream. Ratio changes are requested with load/div,
// held pending, and applied only on a period boundary (or straight away
// while idle), with a single-cycle ack in the cycle the new ratio becomes
// active. Odd ratios give the extra cycle to the high phase.
//
// Ports:
//   clk   in     source clock, rising edge
//   rn    in     asynchronous active-low reset
//   en    in     run request (level); stop waits for the end of the period
//   div   in     requested ratio, sampled when load=1; 0 and 1 become 2
//   load  in     apply request for div
//   ack   out    one-cycle pulse when a pending ratio becomes active
//   clko  out    divided clock, straight from a flop
//   run   out    1 while periods are being produced
//   pcnt  out    completed-period count, saturating (CLKDIV_PERIOD_CNT_EN only)
//   vdd   inout  supply
//   vss   inout  ground
//
// Build option: define CLKDIV_PERIOD_CNT_EN to add the pcnt output and its
// counter. Without it the port and the logic are absent.
//
// State table:
//   state    | meaning
//   S_IDLE   | stopped: clko=0, cnt=0; pending ratio applied on any edge
//   S_ACTIVE | producing periods; cnt walks 0..na-1, clko high while cnt<hi

module clkdiv_prog #(
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 2
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic             ack,
  output logic             clko,
  output logic             run,
`ifdef CLKDIV_PERIOD_CNT_EN
  output logic [15:0]      pcnt,
`endif
  inout  wire              vdd,
  inout  wire              vss
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
  localparam logic [DIV_W-1:0] NA_RST = DIV_W'(RST_DIV);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] na_q, na_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             p_q, p_d;
  logic             clko_q, clko_d;
  logic             ack_q, ack_d;

  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] div_clamped;
  logic             wrap;

  // Supply pins carry no logic function here.
  wire unused_supply = vdd ^ vss;

  assign hi          = na_q - (na_q >> 1);
  assign cnt_inc     = cnt_q + ONE;
  assign wrap        = (cnt_q == (na_q - ONE));
  assign div_clamped = (div < TWO) ? TWO : div;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      na_q    <= NA_RST;
      pend_q  <= NA_RST;
      p_q     <= 1'b0;
      clko_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      na_q    <= na_d;
      pend_q  <= pend_d;
      p_q     <= p_d;
      clko_q  <= clko_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    na_d    = na_q;
    pend_d  = pend_q;
    p_d     = p_q;
    clko_d  = clko_q;
    ack_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        clko_d = 1'b0;
        if (p_q) begin
          na_d  = pend_q;
          p_d   = 1'b0;
          ack_d = 1'b1;
        end
        // A new period always opens high (hi >= 1 for any ratio >= 2).
        if (en) begin
          state_d = S_ACTIVE;
          clko_d  = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (wrap) begin
          cnt_d = '0;
          if (p_q) begin
            na_d  = pend_q;
            p_d   = 1'b0;
            ack_d = 1'b1;
          end
          if (en) begin
            clko_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            clko_d  = 1'b0;
          end
        end else begin
          cnt_d  = cnt_inc;
          clko_d = (cnt_inc < hi);
        end
      end
    endcase

    // Evaluated after the apply so a load on the apply edge becomes the
    // next pending ratio rather than being swallowed.
    if (load) begin
      pend_d = div_clamped;
      p_d    = 1'b1;
    end
  end

  assign clko = clko_q;
  assign ack  = ack_q;
  assign run  = (state_q == S_ACTIVE);

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0] pcnt_q;
  wire         period_end = (state_q == S_ACTIVE) && wrap;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      pcnt_q <= '0;
    end else if (period_end && (pcnt_q != 16'hFFFF)) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign pcnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clkdiv_prog.sv
// Testbench for clkdiv_prog: directed scenarios checked every cycle against a
// period-level model (each started period is expanded into its high/low
// waveform), plus literal waveform and latency expectations.

module tb_clkdiv_prog;

  localparam int DIV_W   = 8;
  localparam int RST_DIV = 2;

  logic             clk;
  logic             rn;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             load;
  logic             ack;
  logic             clko;
  logic             run;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0]      pcnt;
`endif
  wire              vdd = 1'b1;
  wire              vss = 1'b0;

  clkdiv_prog #(.DIV_W(DIV_W), .RST_DIV(RST_DIV)) dut (
    .clk  (clk),
    .rn   (rn),
    .en   (en),
    .div  (div),
    .load (load),
    .ack  (ack),
    .clko (clko),
    .run  (run),
`ifdef CLKDIV_PERIOD_CNT_EN
    .pcnt (pcnt),
`endif
    .vdd  (vdd),
    .vss  (vss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_q holds the clko values still to come in the current period.
  bit m_q[$];
  bit m_run, m_clko, m_ack, m_p;
  int m_n, m_pend, m_pcnt;

  task automatic m_reset();
    m_q.delete();
    m_run  = 1'b0;
    m_clko = 1'b0;
    m_ack  = 1'b0;
    m_p    = 1'b0;
    m_n    = RST_DIV;
    m_pend = RST_DIV;
    m_pcnt = 0;
  endtask

  task automatic m_step();
    bit boundary;
    bit can_start;
    boundary  = m_run && (m_q.size() == 0);
    can_start = !m_run || boundary;
    m_ack = 1'b0;
    if (m_p && can_start) begin
      m_n   = m_pend;
      m_p   = 1'b0;
      m_ack = 1'b1;
    end
    if (boundary && m_pcnt < 65535) m_pcnt++;
    if (load) begin
      m_pend = (int'(div) < 2) ? 2 : int'(div);
      m_p    = 1'b1;
    end
    if (can_start && en) begin
      for (int i = 0; i < m_n; i++) m_q.push_back(i < (m_n + 1) / 2);
      m_clko = m_q.pop_front();
      m_run  = 1'b1;
    end else if (can_start) begin
      m_run  = 1'b0;
      m_clko = 1'b0;
    end else begin
      m_clko = m_q.pop_front();
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rn);
      if (rn !== 1'b1) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("clko", 32'(clko), 32'(m_clko));
      chk("run", 32'(run), 32'(m_run));
      chk("ack", 32'(ack), 32'(m_ack));
`ifdef CLKDIV_PERIOD_CNT_EN
      chk("pcnt", 32'(pcnt), 32'(m_pcnt));
`endif
      if (ack === 1'b1) n_ack++;
    end
  end

  task automatic sample(input int n, output logic [31:0] cbits,
                        output logic [31:0] rbits, output int acks);
    cbits = '0;
    rbits = '0;
    acks  = 0;
    repeat (n) begin
      @(negedge clk);
      cbits = {cbits[30:0], clko};
      rbits = {rbits[30:0], run};
      if (ack === 1'b1) acks++;
    end
  endtask

  // Counts negedges from the drive point until ack; drops load after one edge.
  task automatic wait_ack(input int max, output int lat);
    lat = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (ack === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_cnt(input int k);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_run && (m_n - 1 - m_q.size()) == k) begin
        hit = 1'b1;
        break;
      end
    end
    chk("wait_cnt_timeout", 32'(hit), 32'd1);
  endtask

  task automatic wait_idle();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!m_run) begin
        hit = 1'b1;
        break;
      end
    end
    chk("wait_idle_timeout", 32'(hit), 32'd1);
  endtask

  logic [31:0] cb, rb;
  int          na, lat, a0;

  initial begin
    rn = 1'b0; en = 1'b0; load = 1'b0; div = '0;
    repeat (3) @(negedge clk);
    chk("rst_clko", 32'(clko), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);

    // Reset ratio 2 toggles every cycle, no ack.
    rn = 1'b1; en = 1'b1;
    sample(6, cb, rb, na);
    chk("div2_wave", cb & 32'h3F, 32'h2A);
    chk("div2_run", rb & 32'h3F, 32'h3F);
    chk("div2_noack", 32'(na), 32'd0);

    // Odd ratio loaded while idle, then run.
    en = 1'b0;
    wait_idle();
    div = 8'd5; load = 1'b1;
    wait_ack(10, lat);
    chk("idle_ack_lat", 32'(lat), 32'd2);
    en = 1'b1;
    sample(10, cb, rb, na);
    chk("div5_wave", cb & 32'h3FF, 32'h39C);

    // Mid-run change 4 -> 6 requested at cnt=1.
    div = 8'd4; load = 1'b1;
    wait_ack(20, lat);
    chk("load4_ack", 32'(lat > 0), 32'd1);
    wait_cnt(1);
    div = 8'd6; load = 1'b1;
    wait_ack(20, lat);
    chk("midrun_ack_lat", 32'(lat), 32'd3);
    sample(12, cb, rb, na);
    chk("div6_wave", cb & 32'hFFF, 32'hC71);

    // Clamp + overwrite: 0 then 3 before the boundary, one ack, ratio 3.
    div = 8'd8; load = 1'b1;
    wait_ack(20, lat);
    chk("load8_ack", 32'(lat > 0), 32'd1);
    a0 = n_ack;
    wait_cnt(2);
    div = 8'd0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_cnt(4);
    div = 8'd3; load = 1'b1;
    wait_ack(20, lat);
    chk("overwrite_ack_lat", 32'(lat), 32'd4);
    sample(6, cb, rb, na);
    chk("overwrite_single_ack", 32'(n_ack - a0), 32'd1);
    chk("div3_wave", cb & 32'h3F, 32'h2D);

    // div=1 clamps to 2.
    div = 8'd1; load = 1'b1;
    wait_ack(20, lat);
    chk("load1_ack", 32'(lat > 0), 32'd1);
    sample(4, cb, rb, na);
    chk("clamp1_wave", cb & 32'hF, 32'h5);

    // Stop at cnt=1 of ratio 4, idle, restart.
    div = 8'd4; load = 1'b1;
    wait_ack(20, lat);
    chk("load4b_ack", 32'(lat > 0), 32'd1);
    wait_cnt(1);
    en = 1'b0;
    sample(8, cb, rb, na);
    chk("stop_clko", cb & 32'hFF, 32'h00);
    chk("stop_run", rb & 32'hFF, 32'hC0);
    en = 1'b1;
    @(negedge clk);
    chk("restart_clko", 32'(clko), 32'd1);
    chk("restart_run", 32'(run), 32'd1);

    // Asynchronous reset in the high phase of ratio 6.
    div = 8'd6; load = 1'b1;
    wait_ack(20, lat);
    chk("load6_ack", 32'(lat > 0), 32'd1);
    wait_cnt(1);
    chk("pre_rst_clko", 32'(clko), 32'd1);
    #2 rn = 1'b0;
    #1;
    chk("async_rst_clko", 32'(clko), 32'd0);
    chk("async_rst_run", 32'(run), 32'd0);
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("async_rst_pcnt", 32'(pcnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rn = 1'b1;
    // Ratio back to 2 after reset: three boundaries by the 7th negedge.
    repeat (7) @(negedge clk);
    chk("post_rst_run", 32'(run), 32'd1);
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("post_rst_pcnt", 32'(pcnt), 32'd3);
`endif

    en = 1'b0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
